// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and the MEM stage.
// MEM has priority; each access runs a fixed-length strobe sequence, then one DONE cycle.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        rMem_i,
  input  logic        wMem_i,
  input  logic [15:0] memAddr_i,
  input  logic [15:0] wData_i,
  output logic [15:0] inst_o,
  output logic        if_done,
  output logic [15:0] rData_o,
  output logic        mem_done,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_dout,
  output logic        ram_dir,
  input  logic [15:0] ram_din,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [2:0]  dbg_state_o
);

  // Requesters hold a request level until their done pulse; a grant is
  // committed once taken, even if the request drops afterwards.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WSETUP = 3'd2,
    S_WPULSE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        src_mem_q, src_mem_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      src_mem_q <= 1'b0;
      inst_q    <= 16'h0000;
      rdata_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      src_mem_q <= src_mem_d;
      inst_q    <= inst_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    src_mem_d = src_mem_q;
    inst_d    = inst_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        // A simultaneous read+write from MEM is treated as a write.
        if (wMem_i) begin
          state_d   = S_WSETUP;
          addr_d    = memAddr_i;
          wdata_d   = wData_i;
          src_mem_d = 1'b1;
          cnt_d     = WAIT_LD;
        end else if (rMem_i) begin
          state_d   = S_READ;
          addr_d    = memAddr_i;
          wdata_d   = wData_i;
          src_mem_d = 1'b1;
          cnt_d     = WAIT_LD;
        end else if (if_req) begin
          state_d   = S_READ;
          addr_d    = if_addr;
          wdata_d   = wData_i;
          src_mem_d = 1'b0;
          cnt_d     = WAIT_LD;
        end
      end
      S_READ: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (src_mem_q) rdata_d = ram_din;
          else           inst_d  = ram_din;
        end
      end
      S_WSETUP: state_d = S_WPULSE;
      S_WPULSE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic st_read, st_wset, st_wpul, st_done;
  assign st_read = (state_q == S_READ);
  assign st_wset = (state_q == S_WSETUP);
  assign st_wpul = (state_q == S_WPULSE);
  assign st_done = (state_q == S_DONE);

  // Strobes decode from the async-reset state register so reset releases them immediately.
  assign ram_ce_n = ~(st_read | st_wset | st_wpul);
  assign ram_oe_n = ~st_read;
  assign ram_we_n = ~st_wpul;
  assign ram_dir  = st_wset | st_wpul;
  assign ram_addr = (st_read | st_wset | st_wpul) ? addr_q : 16'h0000;
  assign ram_dout = (st_wset | st_wpul) ? wdata_q : 16'h0000;

  assign if_done      = st_done & ~src_mem_q;
  assign mem_done     = st_done & src_mem_q;
  assign inst_o       = inst_q;
  assign rData_o      = rdata_q;
  assign stallreq_mem = (rMem_i | wMem_i) & ~mem_done;
  assign stallreq_if  = if_req & ~if_done;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with WAIT_CYCLES=1 (index 0) and one with 2 (index 1),
// a small SRAM read model, directed vectors and a done-pulse scoreboard.
module tb_mem_arbiter;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WSETUP = 3'd2;
  localparam logic [2:0] ST_WPULSE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic        clk;
  logic        rst      [2];
  logic        if_req   [2];
  logic [15:0] if_addr  [2];
  logic        rmem     [2];
  logic        wmem     [2];
  logic [15:0] maddr    [2];
  logic [15:0] wdata    [2];
  logic [15:0] inst     [2];
  logic [15:0] rdata    [2];
  logic        if_done  [2];
  logic        mem_done [2];
  logic        st_if    [2];
  logic        st_mem   [2];
  logic [15:0] raddr    [2];
  logic [15:0] rdout    [2];
  logic        rdir     [2];
  logic [15:0] rdin     [2];
  logic        ce_n     [2];
  logic        oe_n     [2];
  logic        we_n     [2];
  logic [2:0]  dbg      [2];

  int n_cmp  = 0;
  int n_fail = 0;
  // {instance, source is MEM, expected inst_o/rData_o at the done pulse}
  logic [17:0] exp_q[$];

  mem_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst[0]), .if_req(if_req[0]), .if_addr(if_addr[0]),
    .rMem_i(rmem[0]), .wMem_i(wmem[0]), .memAddr_i(maddr[0]), .wData_i(wdata[0]),
    .inst_o(inst[0]), .if_done(if_done[0]), .rData_o(rdata[0]), .mem_done(mem_done[0]),
    .stallreq_if(st_if[0]), .stallreq_mem(st_mem[0]), .ram_addr(raddr[0]),
    .ram_dout(rdout[0]), .ram_dir(rdir[0]), .ram_din(rdin[0]), .ram_ce_n(ce_n[0]),
    .ram_oe_n(oe_n[0]), .ram_we_n(we_n[0]), .dbg_state_o(dbg[0])
  );

  mem_arbiter #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst[1]), .if_req(if_req[1]), .if_addr(if_addr[1]),
    .rMem_i(rmem[1]), .wMem_i(wmem[1]), .memAddr_i(maddr[1]), .wData_i(wdata[1]),
    .inst_o(inst[1]), .if_done(if_done[1]), .rData_o(rdata[1]), .mem_done(mem_done[1]),
    .stallreq_if(st_if[1]), .stallreq_mem(st_mem[1]), .ram_addr(raddr[1]),
    .ram_dout(rdout[1]), .ram_dir(rdir[1]), .ram_din(rdin[1]), .ram_ce_n(ce_n[1]),
    .ram_oe_n(oe_n[1]), .ram_we_n(we_n[1]), .dbg_state_o(dbg[1])
  );

  // SRAM model: one fixed word at 0x0040, otherwise address XOR 0xC3C3.
  assign rdin[0] = (raddr[0] == 16'h0040) ? 16'h4A21 : (raddr[0] ^ 16'hC3C3);
  assign rdin[1] = (raddr[1] == 16'h0040) ? 16'h4A21 : (raddr[1] ^ 16'hC3C3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {15'b0, act}, {15'b0, exp});
  endtask

  task automatic chkst(input string name, input logic [2:0] act, input logic [2:0] exp);
    chk(name, {13'b0, act}, {13'b0, exp});
  endtask

  task automatic push(input logic id, input logic is_mem, input logic [15:0] d);
    exp_q.push_back({id, is_mem, d});
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor: every done pulse pops one expectation and checks instance, source and data.
  initial begin
    logic [17:0] e, got;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (if_done[k] && mem_done[k]) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done_overlap: inst %0d both done pulses high", k);
        end
        if (if_done[k] || mem_done[k]) begin
          got = {(k == 1), mem_done[k], mem_done[k] ? rdata[k] : inst[k]};
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected: got %h, expected no done pulse", got);
          end else begin
            e = exp_q.pop_front();
            chk("sb_hi", {14'b0, got[17:16]}, {14'b0, e[17:16]});
            chk("sb_data", got[15:0], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = 16'h0; rmem[k] = 1'b0;
      wmem[k] = 1'b0; maddr[k] = 16'h0; wdata[k] = 16'h0;
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      chkst("rst_state", dbg[k], ST_IDLE);
      chk1("rst_ce_n", ce_n[k], 1'b1);
      chk1("rst_oe_n", oe_n[k], 1'b1);
      chk1("rst_we_n", we_n[k], 1'b1);
      chk1("rst_dir", rdir[k], 1'b0);
      chk("rst_addr", raddr[k], 16'h0);
      chk("rst_dout", rdout[k], 16'h0);
      chk("rst_inst", inst[k], 16'h0);
      chk("rst_rdata", rdata[k], 16'h0);
      chk1("rst_if_done", if_done[k], 1'b0);
      chk1("rst_mem_done", mem_done[k], 1'b0);
    end
    rst[0] = 1'b1; rst[1] = 1'b1;
    cyc();

    // Fetch, WAIT_CYCLES=1
    if_req[0] = 1'b1; if_addr[0] = 16'h0040; push(1'b0, 1'b0, 16'h4A21);
    #1 chk1("f_stall_c0", st_if[0], 1'b1);
    cyc();
    chkst("f_state_c1", dbg[0], ST_READ);
    chk1("f_oe_c1", oe_n[0], 1'b0);
    chk1("f_ce_c1", ce_n[0], 1'b0);
    chk("f_addr_c1", raddr[0], 16'h0040);
    cyc();
    chk1("f_done_c2", if_done[0], 1'b1);
    chk("f_inst_c2", inst[0], 16'h4A21);
    chk1("f_stall_c2", st_if[0], 1'b0);
    chk1("f_oe_c2", oe_n[0], 1'b1);
    chk("f_addr_c2", raddr[0], 16'h0);
    if_req[0] = 1'b0;
    cyc();
    chkst("f_state_c3", dbg[0], ST_IDLE);

    // Write, WAIT_CYCLES=2; request withdrawn right after grant
    wmem[1] = 1'b1; maddr[1] = 16'hBF00; wdata[1] = 16'h1234; push(1'b1, 1'b1, 16'h0000);
    #1 chk1("w_stall_c0", st_mem[1], 1'b1);
    cyc();
    chkst("w_state_c1", dbg[1], ST_WSETUP);
    chk1("w_we_c1", we_n[1], 1'b1);
    chk1("w_ce_c1", ce_n[1], 1'b0);
    chk1("w_dir_c1", rdir[1], 1'b1);
    chk("w_addr_c1", raddr[1], 16'hBF00);
    chk("w_dout_c1", rdout[1], 16'h1234);
    wmem[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chkst("w_state_pulse", dbg[1], ST_WPULSE);
      chk1("w_we_pulse", we_n[1], 1'b0);
      chk("w_addr_pulse", raddr[1], 16'hBF00);
      chk("w_dout_pulse", rdout[1], 16'h1234);
    end
    cyc();
    chk1("w_done_c4", mem_done[1], 1'b1);
    chk1("w_we_c4", we_n[1], 1'b1);
    chk1("w_dir_c4", rdir[1], 1'b0);
    chk("w_addr_c4", raddr[1], 16'h0);
    chk("w_dout_c4", rdout[1], 16'h0);
    cyc();

    // Contention on WAIT_CYCLES=1: MEM read first, IF after DONE
    if_req[0] = 1'b1; if_addr[0] = 16'h0002;
    rmem[0] = 1'b1; maddr[0] = 16'h8001;
    push(1'b0, 1'b1, 16'h43C2); push(1'b0, 1'b0, 16'hC3C1);
    cyc();
    chk("c_addr_c1", raddr[0], 16'h8001);
    chk1("c_stall_if_c1", st_if[0], 1'b1);
    chk1("c_stall_mem_c1", st_mem[0], 1'b1);
    cyc();
    chk1("c_mem_done_c2", mem_done[0], 1'b1);
    chk1("c_if_done_c2", if_done[0], 1'b0);
    chk1("c_stall_if_c2", st_if[0], 1'b1);
    chk1("c_stall_mem_c2", st_mem[0], 1'b0);
    rmem[0] = 1'b0;
    cyc();
    chkst("c_state_c3", dbg[0], ST_IDLE);
    chk1("c_stall_if_c3", st_if[0], 1'b1);
    cyc();
    chk("c_addr_c4", raddr[0], 16'h0002);
    cyc();
    chk1("c_if_done_c5", if_done[0], 1'b1);
    chk("c_rdata_hold", rdata[0], 16'h43C2);
    if_req[0] = 1'b0;
    cyc();

    // Read and write together: write only, rData_o untouched
    rmem[1] = 1'b1; wmem[1] = 1'b1; maddr[1] = 16'h1111; wdata[1] = 16'hAAAA;
    push(1'b1, 1'b1, 16'h0000);
    cyc();
    chkst("rw_state_c1", dbg[1], ST_WSETUP);
    chk1("rw_oe_c1", oe_n[1], 1'b1);
    chk("rw_dout_c1", rdout[1], 16'hAAAA);
    rmem[1] = 1'b0; wmem[1] = 1'b0;
    cyc(); cyc(); cyc();
    chk1("rw_done_c4", mem_done[1], 1'b1);
    cyc();

    // MEM read on WAIT_CYCLES=2, withdrawn after grant
    rmem[1] = 1'b1; maddr[1] = 16'h0010; push(1'b1, 1'b1, 16'hC3D3);
    cyc();
    chk1("r2_oe_c1", oe_n[1], 1'b0);
    rmem[1] = 1'b0;
    cyc();
    chkst("r2_state_c2", dbg[1], ST_READ);
    cyc();
    chk1("r2_done_c3", mem_done[1], 1'b1);
    cyc();

    // Reset during the second WPULSE cycle
    wmem[1] = 1'b1; maddr[1] = 16'h2222; wdata[1] = 16'h5555;
    cyc();
    wmem[1] = 1'b0;
    cyc(); cyc();
    chk1("ar_we_before", we_n[1], 1'b0);
    rst[1] = 1'b0;
    #1;
    chk1("ar_we", we_n[1], 1'b1);
    chk1("ar_ce", ce_n[1], 1'b1);
    chk1("ar_dir", rdir[1], 1'b0);
    chkst("ar_state", dbg[1], ST_IDLE);
    chk("ar_addr", raddr[1], 16'h0);
    chk("ar_rdata", rdata[1], 16'h0);
    cyc();
    rst[1] = 1'b1; if_req[1] = 1'b1; if_addr[1] = 16'h0040; push(1'b1, 1'b0, 16'h4A21);
    cyc();
    chkst("ar_grant_c1", dbg[1], ST_READ);
    cyc(); cyc();
    chk1("ar_if_done_c3", if_done[1], 1'b1);
    if_req[1] = 1'b0;
    cyc();

    // Back-to-back fetches 0x0000..0x0003 on WAIT_CYCLES=1
    if_req[0] = 1'b1; if_addr[0] = 16'h0000;
    push(1'b0, 1'b0, 16'hC3C3); push(1'b0, 1'b0, 16'hC3C2);
    push(1'b0, 1'b0, 16'hC3C1); push(1'b0, 1'b0, 16'hC3C0);
    for (int n = 0; n < 12; n++) begin
      if (n > 0) cyc();
      chk1("b2b_done_cadence", if_done[0], (n % 3) == 2);
      if ((n % 3) == 2) if_addr[0] = 16'(n / 3 + 1);
    end
    if_req[0] = 1'b0;
    cyc(); cyc(); cyc();

    chk("sb_drain", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter WAIT_CYCLES, default 1, giving the number of cycles the SRAM strobe is held low per access (legal range 1..15).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low (rst low = reset).
REQ-004 The block SHALL have the port if_req, input, 1 bit: instruction fetch request.
REQ-005 The block SHALL have the port if_addr, input, 16 bits: fetch address.
REQ-006 The block SHALL have the port rMem_i, input, 1 bit: MEM-stage read request.
REQ-007 The block SHALL have the port wMem_i, input, 1 bit: MEM-stage write request.
REQ-008 The block SHALL have the port memAddr_i, input, 16 bits: MEM-stage address.
REQ-009 The block SHALL have the port wData_i, input, 16 bits: MEM-stage write data.
REQ-010 The block SHALL have the port inst_o, output, 16 bits: fetched instruction.
REQ-011 The block SHALL have the port if_done, output, 1 bit: fetch complete; inst_o valid.
REQ-012 The block SHALL have the port rData_o, output, 16 bits: MEM read data.
REQ-013 The block SHALL have the port mem_done, output, 1 bit: MEM access complete.
REQ-014 The block SHALL have the port stallreq_if, output, 1 bit: fetch stall request to the pipeline controller.
REQ-015 The block SHALL have the port stallreq_mem, output, 1 bit: MEM stall request to the pipeline controller.
REQ-016 The block SHALL have the port ram_addr, output, 16 bits: SRAM address.
REQ-017 The block SHALL have the port ram_dout, output, 16 bits: SRAM write data.
REQ-018 The block SHALL have the port ram_dir, output, 1 bit: 1 = drive ram_dout onto the SRAM bus.
REQ-019 The block SHALL have the port ram_din, input, 16 bits: SRAM read data.
REQ-020 The block SHALL have the ports ram_ce_n, ram_oe_n and ram_we_n, outputs, 1 bit each: active-low SRAM strobes.

Function
REQ-021 The FSM SHALL have five states (IDLE, READ, WSETUP, WPULSE, DONE) and a 4-bit wait counter.
REQ-022 In IDLE the FSM SHALL grant MEM before IF: wMem_i -> WSETUP; else rMem_i -> READ (source MEM); else if_req -> READ (source IF); else stay in IDLE.
REQ-023 On grant the FSM SHALL register the address, the write data and the source, and SHALL load the counter with WAIT_CYCLES.
REQ-024 When rMem_i and wMem_i are both high, the FSM SHALL perform a write only.
REQ-025 In READ: ram_ce_n=0, ram_oe_n=0, ram_dir=0; the counter SHALL decrement each cycle.
REQ-026 On the READ cycle with counter==1, the FSM SHALL capture ram_din into inst_o or rData_o (according to source) and go to DONE.
REQ-027 In WSETUP (exactly 1 cycle): ram_ce_n=0, ram_we_n=1, ram_dir=1, address and data driven; next state WPULSE.
REQ-028 In WPULSE: ram_we_n=0 for WAIT_CYCLES cycles with address and data held; then go to DONE.
REQ-029 DONE SHALL last exactly 1 cycle: strobes inactive, ram_dir=0, no grant, if_done or mem_done =1 (per source); next state IDLE.
REQ-030 if_done and mem_done SHALL be single-cycle pulses and never high together.
REQ-031 inst_o and rData_o SHALL hold their value until the next capture for the same source.
REQ-032 stallreq_mem SHALL be (rMem_i|wMem_i) & ~mem_done, combinational.
REQ-033 stallreq_if SHALL be if_req & ~if_done, combinational; it therefore stays high while IF waits behind MEM.
REQ-034 Latency from the request being seen in IDLE at cycle 0: read done in cycle WAIT_CYCLES+1; write done in cycle WAIT_CYCLES+2.
REQ-035 A request that is withdrawn after grant SHALL still complete (no abort).
REQ-036 Requests arriving in a non-IDLE state SHALL be arbitrated only on return to IDLE.
REQ-037 ram_addr and ram_dout SHALL be 0 in IDLE and DONE.

Reset
REQ-038 While rst=0, immediately and independent of clk: state=IDLE, counter=0, ram_ce_n=ram_oe_n=ram_we_n=1, ram_dir=0, ram_addr=ram_dout=0, inst_o=rData_o=0, if_done=mem_done=0.
REQ-039 A reset asserted mid-access (including during WPULSE) SHALL release ram_we_n to 1 without waiting for a clock edge.
REQ-040 After rst returns to 1, the first grant SHALL occur on the first rising edge at which a request is present.

Verification
REQ-041 Fetch, WAIT_CYCLES=1: if_req=1, if_addr=0x0040, ram_din=0x4A21 -> oe_n low for 1 cycle, inst_o=0x4A21 and if_done=1 in cycle 2, stallreq_if=0 in that cycle.
REQ-042 Write, WAIT_CYCLES=2: wMem_i=1, memAddr_i=0xBF00, wData_i=0x1234 -> 1 setup cycle, we_n low for 2 cycles with addr=0xBF00 and dout=0x1234, mem_done in cycle 4.
REQ-043 Contention: if_req=1 and rMem_i=1 (addr 0x8001) in the same cycle -> MEM read served first with mem_done; IF granted after DONE; stallreq_if high throughout the MEM access.
REQ-044 Both rMem_i=1 and wMem_i=1 -> write cycle only; rData_o unchanged.
REQ-045 Assert rst=0 during the second WPULSE cycle -> we_n=1, ce_n=1 and state IDLE with no clock edge; after release, a new if_req completes normally.
REQ-046 Back-to-back fetches to 0x0000..0x0003 -> one if_done per WAIT_CYCLES+2 cycles, data in order.
